// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle control FSM for the 6-bit-opcode MIPS-style core
module multicycle_sequencer #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   input  logic             alu_done,
   input  logic             branch_taken,
   input  logic             halt_req,
   output logic             mem_req,
   output logic             mem_is_fetch,
   output logic             mem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_start,
   output logic             rf_write,
   output logic [1:0]       rf_wsel,
   output logic [2:0]       state,
   output logic             illegal,
   output logic             bus_err,
   output logic             retired,
   output logic [CNT_W-1:0] retire_cnt
);

   // Wait counter only needs to reach MEM_WAIT_MAX.
   localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

   // Opcode map.
   localparam logic [5:0] OP_MD_LO = 6'h04;
   localparam logic [5:0] OP_MD_HI = 6'h07;
   localparam logic [5:0] OP_J     = 6'h11;
   localparam logic [5:0] OP_JAL   = 6'h12;
   localparam logic [5:0] OP_JR    = 6'h13;
   localparam logic [5:0] OP_BR_LO = 6'h14;
   localparam logic [5:0] OP_BR_HI = 6'h19;
   localparam logic [5:0] OP_LW    = 6'h1F;
   localparam logic [5:0] OP_SW    = 6'h20;
   localparam logic [5:0] OP_LAST  = 6'h21;

   // pc_src / rf_wsel encodings.
   localparam logic [1:0] PC_INC    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_REG    = 2'd3;
   localparam logic [1:0] WSEL_ALU  = 2'd0;
   localparam logic [1:0] WSEL_MEM  = 2'd1;
   localparam logic [1:0] WSEL_LINK = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEMACC = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               exec_first_q, exec_first_d;
   logic               is_muldiv_q, is_muldiv_d;
   logic               is_branch_q, is_branch_d;
   logic               is_lw_q, is_lw_d;
   logic               is_sw_q, is_sw_d;
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;
   logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

   // Ungated per-phase enables from the decode below.
   logic               mem_req_c;
   logic               mem_is_fetch_c;
   logic               mem_we_c;
   logic               ir_write_c;
   logic               pc_write_c;
   logic [1:0]         pc_src_c;
   logic               alu_start_c;
   logic               rf_write_c;
   logic [1:0]         rf_wsel_c;
   logic               retire_c;

   // State register and per-instruction bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         wait_q       <= '0;
         exec_first_q <= 1'b0;
         is_muldiv_q  <= 1'b0;
         is_branch_q  <= 1'b0;
         is_lw_q      <= 1'b0;
         is_sw_q      <= 1'b0;
         illegal_q    <= 1'b0;
         bus_err_q    <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         exec_first_q <= exec_first_d;
         is_muldiv_q  <= is_muldiv_d;
         is_branch_q  <= is_branch_d;
         is_lw_q      <= is_lw_d;
         is_sw_q      <= is_sw_d;
         illegal_q    <= illegal_d;
         bus_err_q    <= bus_err_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Next-state, phase enables, memory timeout and retire accounting.
   always_comb begin
      state_d        = state_q;
      wait_d         = '0;
      exec_first_d   = 1'b0;
      is_muldiv_d    = is_muldiv_q;
      is_branch_d    = is_branch_q;
      is_lw_d        = is_lw_q;
      is_sw_d        = is_sw_q;
      illegal_d      = illegal_q;
      bus_err_d      = bus_err_q;
      retire_cnt_d   = retire_cnt_q;
      mem_req_c      = 1'b0;
      mem_is_fetch_c = 1'b0;
      mem_we_c       = 1'b0;
      ir_write_c     = 1'b0;
      pc_write_c     = 1'b0;
      pc_src_c       = PC_INC;
      alu_start_c    = 1'b0;
      rf_write_c     = 1'b0;
      rf_wsel_c      = WSEL_ALU;
      retire_c       = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req_c      = 1'b1;
            mem_is_fetch_c = 1'b1;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               pc_src_c   = PC_INC;
               state_d    = S_DECODE;
            end else if (wait_q == WAIT_LIMIT) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         S_DECODE: begin
            // Capture the class so later phases never look at opcode again.
            is_muldiv_d = (opcode >= OP_MD_LO) && (opcode <= OP_MD_HI);
            is_branch_d = (opcode >= OP_BR_LO) && (opcode <= OP_BR_HI);
            is_lw_d     = (opcode == OP_LW);
            is_sw_d     = (opcode == OP_SW);
            if (opcode > OP_LAST) begin
               illegal_d = 1'b1;
               state_d   = S_TRAP;
            end else if (opcode == OP_J) begin
               pc_write_c = 1'b1;
               pc_src_c   = PC_JUMP;
               retire_c   = 1'b1;
            end else if (opcode == OP_JAL) begin
               pc_write_c = 1'b1;
               pc_src_c   = PC_JUMP;
               rf_write_c = 1'b1;
               rf_wsel_c  = WSEL_LINK;
               retire_c   = 1'b1;
            end else if (opcode == OP_JR) begin
               pc_write_c = 1'b1;
               pc_src_c   = PC_REG;
               retire_c   = 1'b1;
            end else begin
               exec_first_d = 1'b1;
               state_d      = S_EXEC;
            end
         end

         S_EXEC: begin
            if (is_muldiv_q) begin
               // Start pulse only once; a same-cycle done is accepted.
               alu_start_c = exec_first_q;
               if (alu_done) begin
                  state_d = S_WB;
               end
            end else if (is_branch_q) begin
               if (branch_taken) begin
                  pc_write_c = 1'b1;
                  pc_src_c   = PC_BRANCH;
               end
               retire_c = 1'b1;
            end else if (is_lw_q || is_sw_q) begin
               state_d = S_MEMACC;
            end else begin
               state_d = S_WB;
            end
         end

         S_MEMACC: begin
            mem_req_c = 1'b1;
            mem_we_c  = is_sw_q;
            if (mem_ready) begin
               if (is_sw_q) begin
                  retire_c = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == WAIT_LIMIT) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         S_WB: begin
            rf_write_c = 1'b1;
            rf_wsel_c  = is_lw_q ? WSEL_MEM : WSEL_ALU;
            retire_c   = 1'b1;
         end

         S_HALT: begin
            if (!halt_req) begin
               state_d = S_FETCH;
            end
         end

         S_TRAP: begin
            state_d = S_TRAP;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Any completing phase funnels through here.
      if (retire_c) begin
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
         state_d      = halt_req ? S_HALT : S_FETCH;
      end
   end

   // Enables are forced low while reset is held so an aborted instruction emits nothing.
   assign mem_req      = rst_n & mem_req_c;
   assign mem_is_fetch = rst_n & mem_is_fetch_c;
   assign mem_we       = rst_n & mem_we_c;
   assign ir_write     = rst_n & ir_write_c;
   assign pc_write     = rst_n & pc_write_c;
   assign pc_src       = rst_n ? pc_src_c : 2'd0;
   assign alu_start    = rst_n & alu_start_c;
   assign rf_write     = rst_n & rf_write_c;
   assign rf_wsel      = rst_n ? rf_wsel_c : 2'd0;
   assign retired      = rst_n & retire_c;
   assign state        = state_q;
   assign illegal      = illegal_q;
   assign bus_err      = bus_err_q;
   assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized phase-plan checker for multicycle_sequencer
module tb_multicycle_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic        mem_ready = 1'b0;
   logic        alu_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic        halt_req = 1'b0;
   logic        mem_req, mem_is_fetch, mem_we, ir_write, pc_write;
   logic [1:0]  pc_src;
   logic        alu_start, rf_write;
   logic [1:0]  rf_wsel;
   logic [2:0]  state;
   logic        illegal, bus_err, retired;
   logic [31:0] retire_cnt;

   multicycle_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .alu_done(alu_done), .branch_taken(branch_taken), .halt_req(halt_req),
      .mem_req(mem_req), .mem_is_fetch(mem_is_fetch), .mem_we(mem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_start(alu_start), .rf_write(rf_write), .rf_wsel(rf_wsel),
      .state(state), .illegal(illegal), .bus_err(bus_err),
      .retired(retired), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, mem_is_fetch, mem_we, ir_write, pc_write;
      logic [1:0] pc_src;
      logic       alu_start, rf_write;
      logic [1:0] rf_wsel;
      logic       retired, illegal, bus_err;
   } obs_t;

   typedef struct packed {
      obs_t o;
      logic mr, ad, bt, hr;
   } step_t;

   step_t       plan[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_cnt = 0;
   logic        exp_ill = 0;
   logic        exp_be = 0;
   logic [5:0]  cur_op = 0;
   string       tag = "reset";

   function automatic logic rb();
      return $urandom_range(0, 1) == 1;
   endfunction

   function automatic obs_t base(input logic [2:0] st);
      obs_t r;
      r = '0;
      r.st = st;
      r.illegal = exp_ill;
      r.bus_err = exp_be;
      return r;
   endfunction

   task automatic push(input obs_t o, input logic mr, input logic ad, input logic bt, input logic hr);
      step_t s;
      s.o = o; s.mr = mr; s.ad = ad; s.bt = bt; s.hr = hr;
      plan.push_back(s);
   endtask

   task automatic trap_tail(input int n);
      for (int i = 0; i < n; i++) push(base(3'd6), rb(), rb(), rb(), rb());
   endtask

   // Completing cycle, followed by hold-1 HALT cycles with halt_req high and one releasing cycle.
   task automatic retire_step(input obs_t o, input logic mr, input logic bt, input int hold);
      o.retired = 1'b1;
      push(o, mr, rb(), bt, hold > 0);
      if (hold > 0) begin
         for (int i = 1; i < hold; i++) push(base(3'd5), rb(), rb(), rb(), 1'b1);
         push(base(3'd5), rb(), rb(), rb(), 1'b0);
      end
   endtask

   // Expected cycle-by-cycle trace of one instruction, from the phase rules.
   task automatic plan_instr(input logic [5:0] op, input int fw, input int mw, input int aw,
                             input logic taken, input int hold);
      obs_t o;
      logic is_lw, is_sw;
      is_lw = (op == 6'h1F);
      is_sw = (op == 6'h20);
      o = base(3'd0); o.mem_req = 1; o.mem_is_fetch = 1;
      if (fw > 15) begin
         for (int i = 0; i < 16; i++) push(o, 1'b0, rb(), rb(), rb());
         exp_be = 1'b1;
         trap_tail(4);
         return;
      end
      for (int i = 0; i < fw; i++) push(o, 1'b0, rb(), rb(), rb());
      o.ir_write = 1; o.pc_write = 1; o.pc_src = 2'd0;
      push(o, 1'b1, rb(), rb(), rb());
      o = base(3'd1);
      if (op > 6'h21) begin
         push(o, rb(), rb(), rb(), rb());
         exp_ill = 1'b1;
         trap_tail(4);
         return;
      end
      if (op == 6'h11 || op == 6'h12 || op == 6'h13) begin
         o.pc_write = 1;
         o.pc_src = (op == 6'h13) ? 2'd3 : 2'd2;
         if (op == 6'h12) begin o.rf_write = 1; o.rf_wsel = 2'd2; end
         retire_step(o, rb(), rb(), hold);
         return;
      end
      push(o, rb(), rb(), rb(), rb());
      if (op >= 6'h04 && op <= 6'h07) begin
         for (int i = 0; i <= aw; i++) begin
            o = base(3'd2);
            o.alu_start = (i == 0);
            push(o, rb(), i == aw, rb(), rb());
         end
      end else if (op >= 6'h14 && op <= 6'h19) begin
         o = base(3'd2);
         o.pc_write = taken;
         o.pc_src = taken ? 2'd1 : 2'd0;
         retire_step(o, rb(), taken, hold);
         return;
      end else if (is_lw || is_sw) begin
         push(base(3'd2), rb(), rb(), rb(), rb());
         o = base(3'd3); o.mem_req = 1; o.mem_we = is_sw;
         if (mw > 15) begin
            for (int i = 0; i < 16; i++) push(o, 1'b0, rb(), rb(), rb());
            exp_be = 1'b1;
            trap_tail(4);
            return;
         end
         for (int i = 0; i < mw; i++) push(o, 1'b0, rb(), rb(), rb());
         if (is_sw) begin
            retire_step(o, 1'b1, rb(), hold);
            return;
         end
         push(o, 1'b1, rb(), rb(), rb());
      end else begin
         push(base(3'd2), rb(), rb(), rb(), rb());
      end
      o = base(3'd4); o.rf_write = 1; o.rf_wsel = is_lw ? 2'd1 : 2'd0;
      retire_step(o, rb(), rb(), hold);
   endtask

   // Plays at most maxc planned cycles; opcode is scrambled where it must not matter.
   task automatic execute(input int maxc);
      step_t s;
      obs_t  got;
      int    n;
      n = 0;
      while (plan.size() > 0 && n < maxc) begin
         s = plan.pop_front();
         @(negedge clk);
         rst_n = 1'b1;
         mem_ready = s.mr; alu_done = s.ad; branch_taken = s.bt; halt_req = s.hr;
         opcode = (s.o.st == 3'd0 || s.o.st >= 3'd5) ? 6'($urandom_range(0, 63)) : cur_op;
         #1;
         got = {state, mem_req, mem_is_fetch, mem_we, ir_write, pc_write, pc_src,
                alu_start, rf_write, rf_wsel, retired, illegal, bus_err};
         checks++;
         assert (got === s.o) else begin
            errors++;
            $error("FAIL %s cyc%0d outs got=%h exp=%h", tag, n, got, s.o);
         end
         checks++;
         assert (retire_cnt === exp_cnt) else begin
            errors++;
            $error("FAIL %s cyc%0d retire_cnt got=%0d exp=%0d", tag, n, retire_cnt, exp_cnt);
         end
         if (s.o.retired) exp_cnt++;
         n++;
      end
      plan.delete();
   endtask

   task automatic do_reset();
      obs_t got;
      @(negedge clk);
      rst_n = 1'b0;
      mem_ready = rb(); alu_done = rb(); branch_taken = rb(); halt_req = rb();
      #1;
      got = {state, mem_req, mem_is_fetch, mem_we, ir_write, pc_write, pc_src,
             alu_start, rf_write, rf_wsel, retired, illegal, bus_err};
      checks++;
      assert (got === obs_t'(0)) else begin
         errors++;
         $error("FAIL reset(%s) outs got=%h exp=0", tag, got);
      end
      checks++;
      assert (retire_cnt === 32'd0) else begin
         errors++;
         $error("FAIL reset(%s) retire_cnt got=%0d exp=0", tag, retire_cnt);
      end
      exp_cnt = 0; exp_ill = 0; exp_be = 0;
   endtask

   task automatic run(input string t, input logic [5:0] op, input int fw, input int mw,
                      input int aw, input logic taken, input int hold);
      tag = t;
      cur_op = op;
      plan_instr(op, fw, mw, aw, taken, hold);
      execute(1000);
   endtask

   initial begin
      int fw, mw, aw, hold;
      logic [5:0] op;
      do_reset();
      run("add",       6'h00, 0, 0, 0, 1'b0, 0);
      run("lw_wait3",  6'h1F, 0, 3, 0, 1'b0, 0);
      run("div_5",     6'h06, 0, 0, 5, 1'b0, 0);
      run("beq_taken", 6'h14, 0, 0, 0, 1'b1, 0);
      run("beq_not",   6'h14, 0, 0, 0, 1'b0, 0);
      run("j",         6'h11, 1, 0, 0, 1'b0, 0);
      run("jal",       6'h12, 0, 0, 0, 1'b0, 0);
      run("jr",        6'h13, 2, 0, 0, 1'b0, 0);
      run("sw",        6'h20, 0, 2, 0, 1'b0, 0);
      run("mul_0",     6'h04, 0, 0, 0, 1'b0, 0);
      run("add_halt",  6'h01, 0, 0, 0, 1'b0, 3);
      run("bne_halt",  6'h19, 0, 0, 0, 1'b1, 1);
      run("last_op",   6'h21, 0, 0, 0, 1'b0, 0);
      run("illegal",   6'h2A, 0, 0, 0, 1'b0, 0);
      do_reset();
      run("fetch_to",  6'h00, 16, 0, 0, 1'b0, 0);
      do_reset();
      run("fetch_15",  6'h00, 15, 0, 0, 1'b0, 0);
      run("mem_to",    6'h1F, 0, 16, 0, 1'b0, 0);
      do_reset();
      run("mem_15",    6'h20, 0, 15, 0, 1'b0, 0);
      tag = "abort_lw";
      cur_op = 6'h1F;
      plan_instr(6'h1F, 0, 3, 0, 1'b0, 0);
      execute(5);
      do_reset();
      run("after_abort", 6'h07, 0, 0, 2, 1'b0, 0);

      for (int k = 0; k < 120; k++) begin
         op   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(34, 63)) : 6'($urandom_range(0, 33));
         fw   = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 16) : $urandom_range(0, 2);
         mw   = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 16) : $urandom_range(0, 3);
         aw   = $urandom_range(0, 5);
         hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
         run("rand", op, fw, mw, aw, rb(), hold);
         if (exp_ill || exp_be) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
